enemy_bullet_launcher: RTL

//   Source end of the enemy-bullet interface. Spawns, moves and retires one enemy

---
 rtl/game_pkg.sv | 24 ++
 rtl/eb_cooldown_timer.sv | 29 ++
 rtl/enemy_bullet_launcher.sv | 108 ++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: bullet FSM states, screen geometry and the
// saturating coordinate adder used when spawning bullets.
package game_pkg;

  typedef enum logic [1:0] {
    COOL  = 2'd0,
    READY = 2'd1,
    FLY   = 2'd2
  } eb_state_e;

  localparam int COORD_W         = 10;
  localparam int SCREEN_W        = 640;
  localparam int Y_LIMIT_DEFAULT = 960;
  localparam int COORD_MAX       = (1 << COORD_W) - 1;

  // Adds two coordinates in COORD_W+1 bits and clamps to the top of the range.
  function automatic logic [COORD_W-1:0] sat10(input logic [COORD_W-1:0] a,
                                               input logic [COORD_W-1:0] b);
    logic [COORD_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[COORD_W] ? COORD_W'(COORD_MAX) : sum[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/eb_cooldown_timer.sv
// Frame-tick-gated cooldown counter. Counts ticks while not cleared and
// pulses done_o on the tick that completes COOLDOWN ticks.
module eb_cooldown_timer #(
  parameter int COOLDOWN = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic tick_i,
  output logic done_o
);

  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  logic [CW-1:0] count_q;
  logic          last_q;

  assign last_q = (count_q == CW'(COOLDOWN - 1));
  assign done_o = tick_i && !clear_i && last_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      count_q <= '0;
    end else if (tick_i) begin
      count_q <= last_q ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/enemy_bullet_launcher.sv
// One enemy's bullet: waits out a cooldown, spawns under the enemy on a frame
// tick, falls SPEED pixels per tick and retires at Y_LIMIT or on a judge hit.
module enemy_bullet_launcher
  import game_pkg::*;
#(
  parameter int SPEED    = 4,
  parameter int COOLDOWN = 30,
  parameter int X_OFS    = 20,
  parameter int Y_OFS    = 40,
  parameter int Y_LIMIT  = Y_LIMIT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               game_active,
  input  logic               enemy_en,
  input  logic [COORD_W-1:0] enemy_x,
  input  logic [COORD_W-1:0] enemy_y,
  input  logic               bullet_hit,
  output logic [COORD_W-1:0] eb_x,
  output logic [COORD_W-1:0] eb_y,
  output logic               enemy_bullet_en,
  output logic               fire
);

  eb_state_e          state_q;
  logic [COORD_W-1:0] eb_x_q;
  logic [COORD_W-1:0] eb_y_q;
  logic               en_q;
  logic               fire_q;

  logic               cool_clear;
  logic               cool_done;
  logic [COORD_W:0]   y_next;
  logic               y_out;

  // Counter only runs in COOL, so it is always zero when COOL is re-entered.
  assign cool_clear = (state_q != COOL) || !game_active;

  eb_cooldown_timer #(
    .COOLDOWN(COOLDOWN)
  ) u_cooldown (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(cool_clear),
    .tick_i (frame_tick),
    .done_o (cool_done)
  );

  assign y_next = {1'b0, eb_y_q} + (COORD_W + 1)'(SPEED);
  assign y_out  = (y_next >= (COORD_W + 1)'(Y_LIMIT)) || (y_next > (COORD_W + 1)'(COORD_MAX));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= COOL;
      eb_x_q  <= '0;
      eb_y_q  <= '0;
      en_q    <= 1'b0;
      fire_q  <= 1'b0;
    end else begin
      fire_q <= 1'b0;
      if (!game_active) begin
        state_q <= COOL;
        en_q    <= 1'b0;
      end else begin
        case (state_q)
          COOL: begin
            en_q <= 1'b0;
            if (cool_done) state_q <= READY;
          end
          READY: begin
            if (frame_tick && enemy_en) begin
              eb_x_q  <= sat10(enemy_x, COORD_W'(X_OFS));
              eb_y_q  <= sat10(enemy_y, COORD_W'(Y_OFS));
              en_q    <= 1'b1;
              fire_q  <= 1'b1;
              state_q <= FLY;
            end
          end
          FLY: begin
            // A hit wins over a coincident move tick: position freezes where it was hit.
            if (bullet_hit) begin
              en_q    <= 1'b0;
              state_q <= COOL;
            end else if (frame_tick) begin
              if (y_out) begin
                en_q    <= 1'b0;
                state_q <= COOL;
              end else begin
                eb_y_q <= y_next[COORD_W-1:0];
              end
            end
          end
          default: begin
            en_q    <= 1'b0;
            state_q <= COOL;
          end
        endcase
      end
    end
  end

  assign eb_x            = eb_x_q;
  assign eb_y            = eb_y_q;
  assign enemy_bullet_en = en_q;
  assign fire            = fire_q;

endmodule
